// File: rtl/matrix_pkg.sv
// +----------------------------------------------------------------------------+
// | matrix_pkg : constants and types shared by the 2x2 matrix multiplier       |
// | Rev 1.0    : initial release                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package matrix_pkg;
  localparam int ELEM_W      = 3;
  localparam int ENTRY_W     = 4;
  localparam int N_ENTRIES   = 4;
  localparam int RES_FIELD_W = 2 * ELEM_W + 1;
  localparam int RES_W       = N_ENTRIES * RES_FIELD_W;

  localparam logic [ENTRY_W-1:0] ENTRY_IDLE = 4'd8;
  localparam logic [ENTRY_W-1:0] ENTRY_LAST = 4'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit offset of result field idx: c00=0, c01=1, c10=2, c11=3.
  function automatic int field_off(input int idx);
    return idx * RES_FIELD_W;
  endfunction
endpackage

`default_nettype wire

// File: rtl/element_mac.sv
// +----------------------------------------------------------------------------+
// | element_mac : combinational unsigned product and product+accumulator       |
// | Rev 1.0     : initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module element_mac
  import matrix_pkg::*;
#(
  parameter int W = ELEM_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2*W:0] acc,
  output logic [2*W:0] prod,
  output logic [2*W:0] sum
);
  logic [2*W-1:0] raw;

  assign raw  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign prod = {1'b0, raw};
  // Two products of (2^W-1)^2 always fit in 2W+1 bits, so no carry out.
  assign sum  = acc + prod;
endmodule

`default_nettype wire

// File: rtl/matrix_mac.sv
// +----------------------------------------------------------------------------+
// | matrix_mac : index sequencer and MAC stage for the 2x2 matrix multiplier   |
// | Rev 1.0    : initial release                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module matrix_mac
  import matrix_pkg::*;
#(
  parameter int W = ELEM_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [W-1:0]           element_a,
  input  logic [W-1:0]           element_b,
  output logic [ENTRY_W-1:0]     entry_out,
  output logic                   busy,
  output logic                   done,
  output logic [4*(2*W+1)-1:0]   result
);
  localparam int FW = 2 * W + 1;

  state_t             state;
  state_t             next_state;
  logic [ENTRY_W-1:0] next_entry;
  logic               smp_vld;
  logic [ENTRY_W-1:0] smp_idx;
  logic               take;
  logic [FW-1:0]      acc;
  logic [FW-1:0]      prod;
  logic [FW-1:0]      sum;
  logic [FW-1:0]      shadow [N_ENTRIES];
  logic [4*FW-1:0]    shadow_flat;

  element_mac #(.W(W)) u_mac (
    .a    (element_a),
    .b    (element_b),
    .acc  (acc),
    .prod (prod),
    .sum  (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    next_entry = ENTRY_IDLE;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_RUN;
          next_entry = '0;
        end
      end
      ST_RUN: begin
        if (entry_out != ENTRY_IDLE && entry_out != ENTRY_LAST)
          next_entry = entry_out + 1'b1;
        if (smp_vld && smp_idx == ENTRY_LAST)
          next_state = ST_DONE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  // Selector data for entry_out arrives by the next posedge, so use it now.
  assign take = (state == ST_RUN) && (entry_out != ENTRY_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_out <= ENTRY_IDLE;
      smp_idx   <= ENTRY_IDLE;
      smp_vld   <= 1'b0;
      acc       <= '0;
      for (int i = 0; i < N_ENTRIES; i++) shadow[i] <= '0;
    end else begin
      entry_out <= next_entry;
      smp_idx   <= entry_out;
      smp_vld   <= take;
      if (take) begin
        if (!entry_out[0]) acc <= prod;
        else               shadow[entry_out[2:1]] <= sum;
      end
    end
  end

  for (genvar i = 0; i < N_ENTRIES; i++) begin : g_pack
    assign shadow_flat[i*FW +: FW] = shadow[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      result <= '0;
    else if (state == ST_RUN && next_state == ST_DONE)
      result <= shadow_flat;
  end
endmodule

`default_nettype wire

// File: tb/tb_matrix_mac.sv
// +----------------------------------------------------------------------------+
// | tb_matrix_mac : directed bench with negedge A/B selector models            |
// | Rev 1.0       : initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_matrix_mac;
  import matrix_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [ELEM_W-1:0]  element_a;
  logic [ELEM_W-1:0]  element_b;
  logic [ENTRY_W-1:0] entry_out;
  logic               busy;
  logic               done;
  logic [RES_W-1:0]   result;

  logic [ELEM_W-1:0]  ma [4];  // a00, a01, a10, a11
  logic [ELEM_W-1:0]  mb [4];  // b00, b01, b10, b11

  int n_vec;
  int n_err;

  matrix_mac #(.W(ELEM_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .element_a (element_a),
    .element_b (element_b),
    .entry_out (entry_out),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [ELEM_W-1:0] sel_a(input logic [ENTRY_W-1:0] idx);
    if (idx > 4'd7) return '0;
    return ma[{idx[2], idx[0]}];
  endfunction

  function automatic logic [ELEM_W-1:0] sel_b(input logic [ENTRY_W-1:0] idx);
    if (idx > 4'd7) return '0;
    return mb[{idx[0], idx[1]}];
  endfunction

  always @(negedge clk) begin
    element_a <= sel_a(entry_out);
    element_b <= sel_b(entry_out);
  end

  function automatic logic [RES_W-1:0] pk(input int c00, input int c01, input int c10, input int c11);
    logic [RES_W-1:0] r;
    r = '0;
    r[field_off(0) +: RES_FIELD_W] = RES_FIELD_W'(c00);
    r[field_off(1) +: RES_FIELD_W] = RES_FIELD_W'(c01);
    r[field_off(2) +: RES_FIELD_W] = RES_FIELD_W'(c10);
    r[field_off(3) +: RES_FIELD_W] = RES_FIELD_W'(c11);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_mats(input int a00, input int a01, input int a10, input int a11,
                          input int b00, input int b01, input int b10, input int b11);
    ma[0] = ELEM_W'(a00); ma[1] = ELEM_W'(a01); ma[2] = ELEM_W'(a10); ma[3] = ELEM_W'(a11);
    mb[0] = ELEM_W'(b00); mb[1] = ELEM_W'(b01); mb[2] = ELEM_W'(b10); mb[3] = ELEM_W'(b11);
  endtask

  // Called one step after a posedge with the block in IDLE; returns one step
  // after edge 10 of the run, again in IDLE.
  task automatic run_mult(input string tag, input bit spam,
                          input logic [RES_W-1:0] exp_res, input logic [RES_W-1:0] old_res);
    int busys;
    int dones;
    logic [ENTRY_W-1:0] exp_e;
    busys = 0;
    dones = 0;
    check({tag, "_pre_entry"}, 32'(entry_out), 32'(ENTRY_IDLE));
    start = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk);
      #1;
      start = spam;
      exp_e = (k <= 7) ? ENTRY_W'(k) : ENTRY_IDLE;
      check($sformatf("%s_entry_e%0d", tag, k), 32'(entry_out), 32'(exp_e));
      busys += int'(busy);
      dones += int'(done);
      if (k == 0 || k == 8) check($sformatf("%s_hold_e%0d", tag, k), 32'(result), 32'(old_res));
      if (k == 9) begin
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
      end
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 32'(busys), 32'd10);
    check({tag, "_done_count"}, 32'(dones), 32'd1);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [RES_W-1:0] r_basic;
    logic [RES_W-1:0] r_max;
    logic [RES_W-1:0] r_ident;
    bit found;
    n_vec = 0;
    n_err = 0;
    r_basic = pk(19, 8, 43, 22);
    r_max   = pk(98, 98, 98, 98);
    r_ident = pk(6, 5, 4, 3);

    rst_n = 1'b0;
    start = 1'b0;
    set_mats(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_entry", 32'(entry_out), 32'(ENTRY_IDLE));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    set_mats(1, 2, 3, 4, 5, 6, 7, 1);
    run_mult("basic", 1'b0, r_basic, '0);

    // Abort a run mid-way with an asynchronous reset.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (entry_out == 4'd4) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("midrst_reach_idx4", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_entry", 32'(entry_out), 32'(ENTRY_IDLE));
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    set_mats(7, 7, 7, 7, 7, 7, 7, 7);
    run_mult("max", 1'b0, r_max, '0);

    set_mats(6, 5, 4, 3, 1, 0, 0, 1);
    run_mult("ident_spam", 1'b1, r_ident, r_max);

    set_mats(1, 2, 3, 4, 5, 6, 7, 1);
    run_mult("b2b_first", 1'b0, r_basic, r_ident);
    set_mats(7, 7, 7, 7, 7, 7, 7, 7);
    run_mult("b2b_second", 1'b0, r_max, r_basic);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
